lifo_pop_packer: RTL and testbench
==================================

// Module: lifo_pop_packer
// PURPOSE
//   Downstream consumer of the parameterized LIFO buffer. Pops words from the LIFO via its
//   read/val/data_out interface and packs PACK_N consecutive pops into one wide word.
//   Presents that word on a valid/ready stream toward the Ethernet TX path.
//   Partial words are emitted on flush.
// PARAMETERS
//   DATA_W   8   width of one LIFO word
//   PACK_N   4   LIFO words per output word (>=2)
//   TIMEOUT  16  idle cycles before a partial word is forced out (only with macro, >=2)
// PORTS
//   clk        in   1              single clock, all logic on posedge
//   reset      in   1              asynchronous, active-low; clears all state immediately
//   lifo_data  in   DATA_W         LIFO top-of-stack word (LIFO data_out)
//   lifo_val   in   1              LIFO non-empty (LIFO val)
//   lifo_read  out  1              pop request to LIFO (LIFO read)
//   flush      in   1              emit current partial word
//   out_data   out  DATA_W*PACK_N  packed word; lane i = out_data[DATA_W*i +: DATA_W]
//   out_cnt    out  $clog2(PACK_N+1)  number of valid lanes in out_data
//   out_valid  out  1              out_data/out_cnt valid
//   out_ready  in   1              downstream accepts when out_valid & out_ready
// BEHAVIOUR
//   - Reset: state=FILL, idx=0, lane regs=0, out_valid=0, out_cnt=0, out_data=0, timer=0.
//   - States: FILL (collect pops), HOLD (present word). Only these two are used.
//   - FILL: lifo_read = lifo_val (combinational); a pop is lifo_read=1 at posedge.
//     The pop writes lifo_data into lane idx and increments idx.
//     First pop (most recent LIFO entry) goes to lane 0 (LSBs).
//   - FILL, pop with idx==PACK_N-1: next cycle HOLD, out_cnt=PACK_N, idx->0.
//   - FILL, flush=1 and (idx>0 or pop this cycle): next cycle HOLD.
//     out_cnt = idx + pop, and the word popped in the same cycle is included.
//     flush with idx==0 and no pop is ignored. flush is level, sampled only in FILL.
//   - Unfilled lanes are 0 in out_data.
//   - HOLD: out_valid=1; lifo_read=0; out_data/out_cnt stable until handshake.
//     On out_valid & out_ready: next cycle FILL, out_valid=0, lanes cleared to 0.
//   - Throughput: PACK_N pops + 1 HOLD cycle minimum per word; no pop in the handshake cycle.
//   - LIFO never popped while empty (lifo_read gated by lifo_val); no underflow handling needed.
//   - Reset mid-fill/mid-hold: partial data discarded, outputs to reset values asynchronously.
//     Words already popped from the LIFO are lost.
// CONFIGURATION
//   Macro LIFO_POP_PACKER_TIMEOUT_EN:
//   - Defined: in FILL with idx>0, timer counts cycles with no pop and resets on each pop.
//     On timer==TIMEOUT-1 the block behaves exactly like a flush.
//     timer is cleared on entering HOLD.
//   - Undefined: no timer logic, TIMEOUT ignored; partial words leave only via flush.
// STRUCTURE
//   - Package lifo_pkg:
//     - state encodings ST_FILL=1'b0, ST_HOLD=1'b1
//     - localparam function for index width clog2(PACK_N+1)
//     - shared DATA_W default
//   - Sub-module pack_timeout_ctr: idle counter with clear/en/expire.
//     Instantiated only under LIFO_POP_PACKER_TIMEOUT_EN.
//   - Lane registers and FSM stay in this module.
// TESTING (DATA_W=8, PACK_N=4, TIMEOUT=16, LIFO instance upstream)
//   1 push 11,22,33,44; out_ready=1 -> 4 pops, out_valid 1 cycle later,
//     out_data=32'h11223344, out_cnt=4.
//   2 full word held, out_ready=0 for 10 cycles -> out_valid stays 1, data stable,
//     lifo_read=0, LIFO count unchanged.
//   3 pop AA then BB, flush=1 -> out_data=32'h0000BBAA, out_cnt=2.
//   4 flush=1 with idx=0, lifo_val=0 -> out_valid stays 0, state stays FILL.
//   5 reset low after 2 pops -> out_valid/out_cnt/out_data=0 same cycle;
//     after release, next 4 pops form a fresh word with out_cnt=4.
//   6 1 pop (5A) then lifo_val=0 for 16 cycles:
//     - with macro: out_valid=1, out_data=32'h0000005A, out_cnt=1
//     - without macro: out_valid stays 0

Source files
------------

// File: rtl/lifo_pkg.sv
// Shared types and helpers for the LIFO pop packer and its idle timer.
package lifo_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int unsigned LIFO_DATA_W = 8;

    // Width needed to hold the values 0..n inclusive.
    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pack_timeout_ctr.sv
// Idle-cycle counter for the pop packer; expire_c is high once TIMEOUT-1 idle cycles have accrued.
module pack_timeout_ctr
    import lifo_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = idx_w(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_c = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Saturates at the expire value so a held-off clear cannot wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lifo_pop_packer.sv
// Pops LIFO words and packs PACK_N of them (first pop in lane 0) into one valid/ready word.
// Optional idle timeout forcing out partial words: LIFO_POP_PACKER_TIMEOUT_EN.
module lifo_pop_packer
    import lifo_pkg::*;
#(
    parameter int unsigned DATA_W  = LIFO_DATA_W,
    parameter int unsigned PACK_N  = 4
`ifdef LIFO_POP_PACKER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          lifo_data,
    input  logic                       lifo_val,
    output logic                       lifo_read,
    input  logic                       flush,
    output logic [DATA_W*PACK_N-1:0]   out_data,
    output logic [idx_w(PACK_N)-1:0]   out_cnt,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int unsigned IDX_W = idx_w(PACK_N);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               cnt_q, cnt_d;
    logic [PACK_N-1:0][DATA_W-1:0]  lane_q, lane_d;
    logic                           valid_q, valid_d;

    logic pop_c;
    logic expire_c;
    logic flush_c;
    logic to_hold_c;

    assign pop_c     = (state_q == ST_FILL) && lifo_val;
    assign lifo_read = pop_c;
    assign flush_c   = flush | expire_c;

    assign out_data  = lane_q;
    assign out_cnt   = cnt_q;
    assign out_valid = valid_q;

`ifdef LIFO_POP_PACKER_TIMEOUT_EN
    logic tmr_en_c;
    logic tmr_clr_c;
    logic tmr_exp_c;

    // Count only idle cycles of a partially filled word; any pop or leaving FILL restarts it.
    assign tmr_en_c  = (state_q == ST_FILL) && (idx_q != '0) && !pop_c;
    assign tmr_clr_c = !tmr_en_c || to_hold_c;
    assign expire_c  = tmr_exp_c && (state_q == ST_FILL) && (idx_q != '0);

    pack_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr      (tmr_clr_c),
        .en       (tmr_en_c),
        .expire_c (tmr_exp_c)
    );
`else
    assign expire_c = 1'b0;
`endif

    // Next-state, lane capture and word hand-off.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        lane_d    = lane_q;
        valid_d   = valid_q;
        to_hold_c = 1'b0;

        case (state_q)
            ST_FILL: begin
                if (pop_c) begin
                    for (int unsigned i = 0; i < PACK_N; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            lane_d[i] = lifo_data;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                end

                if (pop_c && (idx_q == IDX_W'(PACK_N - 1))) begin
                    to_hold_c = 1'b1;
                    cnt_d     = IDX_W'(PACK_N);
                end else if (flush_c && ((idx_q != '0) || pop_c)) begin
                    to_hold_c = 1'b1;
                    cnt_d     = idx_q + IDX_W'(pop_c);
                end

                if (to_hold_c) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                    idx_d   = '0;
                end
            end

            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_FILL;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    lane_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_lifo_pop_packer.sv
// Self-checking bench for lifo_pop_packer with a behavioural LIFO and a queue-based packing model.
module tb_lifo_pop_packer;

    localparam int DW = 8;
    localparam int PN = 4;
    localparam int TO = 16;
`ifdef LIFO_POP_PACKER_TIMEOUT_EN
    localparam bit TMR_EN = 1'b1;
`else
    localparam bit TMR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] lifo_data;
    logic          lifo_val;
    logic          lifo_read;
    logic          flush;
    logic [31:0]   out_data;
    logic [2:0]    out_cnt;
    logic          out_valid;
    logic          out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] stk[$];

    always #5 clk = ~clk;

    lifo_pop_packer #(
        .DATA_W (DW),
        .PACK_N (PN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lifo_data (lifo_data),
        .lifo_val  (lifo_val),
        .lifo_read (lifo_read),
        .flush     (flush),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic logic [31:0] pack(input logic [7:0] q[$]);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < q.size(); i++) r[8*i +: 8] = q[i];
        return r;
    endfunction

    // Drive the LIFO face for one cycle and pop the bench stack if the DUT read.
    task automatic cycle();
        logic rd;
        lifo_val  = (stk.size() != 0);
        lifo_data = (stk.size() != 0) ? stk[stk.size()-1] : 8'h00;
        #1 rd = lifo_read;
        @(posedge clk);
        if (rd && stk.size() != 0) void'(stk.pop_back());
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        lifo_val  = 1'b0;
        lifo_data = 8'h00;
        out_ready = 1'b0;
        stk.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        flush     = 1'b0;
        lifo_val  = 1'b0;
        lifo_data = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", out_cnt); end
        n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
        n_cmp++; if (lifo_read !== 1'b0) begin n_fail++; $display("FAIL reset_read got %b exp 0", lifo_read); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_word();
        do_reset();
        stk.push_back(8'h11); stk.push_back(8'h22); stk.push_back(8'h33); stk.push_back(8'h44);
        out_ready = 1'b1;
        repeat (3) cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_early_valid got %b exp 0", out_valid); end
        cycle();
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid got %b exp 1", out_valid); end
        n_cmp++; if (out_data !== 32'h11223344) begin n_fail++; $display("FAIL full_data got %h exp 11223344", out_data); end
        n_cmp++; if (out_cnt !== 3'd4) begin n_fail++; $display("FAIL full_cnt got %0d exp 4", out_cnt); end
        n_cmp++; if (stk.size() !== 0) begin n_fail++; $display("FAIL full_pops left %0d exp 0", stk.size()); end
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_hs_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL full_hs_data got %h exp 0", out_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 1; i <= 8; i++) stk.push_back(8'(i));
        out_ready = 1'b0;
        repeat (4) cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            lifo_val = (stk.size() != 0);
            #1;
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h05060708 || out_cnt !== 3'd4) begin
                n_fail++; $display("FAIL hold_stable k=%0d got v=%b d=%h c=%0d exp v=1 d=05060708 c=4", k, out_valid, out_data, out_cnt);
            end
            n_cmp++; if (lifo_read !== 1'b0) begin n_fail++; $display("FAIL hold_read k=%0d got %b exp 0", k, lifo_read); end
            n_cmp++; if (stk.size() !== 4) begin n_fail++; $display("FAIL hold_depth k=%0d got %0d exp 4", k, stk.size()); end
        end
        out_ready = 1'b1;
        cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_hs_valid got %b exp 0", out_valid); end
        n_cmp++; if (stk.size() !== 4) begin n_fail++; $display("FAIL bp_hs_nopop depth %0d exp 4", stk.size()); end
    endtask

    task automatic test_flush_partial();
        do_reset();
        stk.push_back(8'hBB); stk.push_back(8'hAA);
        out_ready = 1'b0;
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_valid got %b exp 1", out_valid); end
        n_cmp++; if (out_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL flush_data got %h exp 0000bbaa", out_data); end
        n_cmp++; if (out_cnt !== 3'd2) begin n_fail++; $display("FAIL flush_cnt got %0d exp 2", out_cnt); end
    endtask

    task automatic test_flush_empty();
        do_reset();
        flush = 1'b1;
        repeat (3) cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL eflush_valid got %b exp 0", out_valid); end
        flush = 1'b0;
        stk.push_back(8'h01); stk.push_back(8'h02); stk.push_back(8'h03); stk.push_back(8'h04);
        repeat (4) cycle();
        n_cmp++; if (out_valid !== 1'b1 || out_cnt !== 3'd4 || out_data !== 32'h01020304) begin
            n_fail++; $display("FAIL eflush_fill got v=%b c=%0d d=%h exp v=1 c=4 d=01020304", out_valid, out_cnt, out_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stk.push_back(8'hC1); stk.push_back(8'hC2); stk.push_back(8'hC3); stk.push_back(8'hC4);
        out_ready = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_cnt !== 3'd0 || out_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_fill got v=%b c=%0d d=%h exp all 0", out_valid, out_cnt, out_data);
        end
        lifo_val = 1'b0;
        stk.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        stk.push_back(8'hD1); stk.push_back(8'hD2); stk.push_back(8'hD3); stk.push_back(8'hD4);
        repeat (4) cycle();
        n_cmp++; if (out_valid !== 1'b1 || out_cnt !== 3'd4 || out_data !== 32'hD1D2D3D4) begin
            n_fail++; $display("FAIL rst_fresh got v=%b c=%0d d=%h exp v=1 c=4 d=d1d2d3d4", out_valid, out_cnt, out_data);
        end
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_cnt !== 3'd0 || out_data !== 32'h0) begin
            n_fail++; $display("FAIL rst_hold got v=%b c=%0d d=%h exp all 0", out_valid, out_cnt, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_timeout();
        do_reset();
        stk.push_back(8'h5A);
        out_ready = 1'b0;
        cycle();
        repeat (TO - 1) cycle();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_early got %b exp 0", out_valid); end
        cycle();
        if (TMR_EN) begin
            n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h0000005A || out_cnt !== 3'd1) begin
                n_fail++; $display("FAIL idle_timeout got v=%b d=%h c=%0d exp v=1 d=0000005a c=1", out_valid, out_data, out_cnt);
            end
        end else begin
            repeat (8) cycle();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_notimer got %b exp 0", out_valid); end
        end
    endtask

    task automatic test_random();
        logic [7:0]  cur[$];
        logic [31:0] held;
        int          held_cnt;
        bit          hold;
        int          idle;
        bit          pop, had, expire, go, push;
        held = '0; held_cnt = 0; hold = 1'b0; idle = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 200) % 3;
            if (ph == 0) push = ($urandom_range(0, 2) == 0);
            else if (ph == 1) push = ($urandom_range(0, 39) == 0);
            else push = ($urandom_range(0, 4) != 0);
            if (push && stk.size() < 12) stk.push_back(8'($urandom));
            flush     = (ph == 1) ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            lifo_val  = (stk.size() != 0);
            lifo_data = (stk.size() != 0) ? stk[stk.size()-1] : 8'h00;
            #1;
            pop = !hold && lifo_val;
            n_cmp++; if (lifo_read !== pop) begin n_fail++; $display("FAIL rnd_read i=%0d got %b exp %b", i, lifo_read, pop); end
            if (!hold) begin
                had    = (cur.size() != 0);
                expire = TMR_EN && had && (idle == TO - 1);
                if (pop) cur.push_back(lifo_data);
                go = (cur.size() == PN) || ((flush || expire) && cur.size() != 0);
                if (go || pop || !had) idle = 0;
                else idle++;
                if (go) begin
                    held     = pack(cur);
                    held_cnt = cur.size();
                    cur.delete();
                    hold     = 1'b1;
                end
            end else if (out_ready) begin
                hold = 1'b0;
            end
            @(posedge clk);
            if (pop) void'(stk.pop_back());
            #1;
            n_cmp++; if (out_valid !== hold) begin n_fail++; $display("FAIL rnd_valid i=%0d got %b exp %b", i, out_valid, hold); end
            n_cmp++; if (out_cnt !== 3'(hold ? held_cnt : 0)) begin
                n_fail++; $display("FAIL rnd_cnt i=%0d got %0d exp %0d", i, out_cnt, hold ? held_cnt : 0);
            end
            if (hold) begin
                n_cmp++; if (out_data !== held) begin n_fail++; $display("FAIL rnd_data i=%0d got %h exp %h", i, out_data, held); end
            end
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        lifo_val  = 1'b0;
        lifo_data = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush_partial();
        test_flush_empty();
        test_reset_mid();
        test_idle_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
